// File: rtl/modexp_controller.sv
// Modular exponentiation sequencer (right-to-left square-and-multiply).
// All arithmetic is delegated to an external modular multiplier via a four-phase handshake.
module modexp_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             modexp_start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             modexp_done,
  output logic             modexp_error,
  output logic [WIDTH-1:0] result,
  output logic             mm_ready,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_n,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_result,
  output logic [2:0]       dbg_state_o
);

  // mm handshake: mm_ready rises with mm_a/mm_b/mm_n and holds them constant until
  // mm_done is seen high; mm_ready then falls, and no new request is raised until
  // mm_done has been observed low again.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    MUL_REQ = 3'd2,
    MUL_REL = 3'd3,
    SQR_REQ = 3'd4,
    SQR_REL = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q, b_q, e_q, n_q;
  logic [WIDTH-1:0] result_q, mm_a_q, mm_b_q, mm_n_q;
  logic             done_q, error_q, mm_ready_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      b_q        <= '0;
      e_q        <= '0;
      n_q        <= '0;
      result_q   <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_n_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mm_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (modexp_start) begin
            b_q     <= base;
            e_q     <= exponent;
            n_q     <= modulus;
            acc_q   <= WIDTH'(1);
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (n_q == '0) begin
            error_q  <= 1'b1;
            result_q <= '0;
            state_q  <= DONE;
          end else if (e_q == '0) begin
            result_q <= (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
            state_q  <= DONE;
          end else if (!mm_done) begin
            // A stale mm_done (e.g. left over from a reset) holds us here.
            mm_ready_q <= 1'b1;
            mm_n_q     <= n_q;
            if (e_q[0]) begin
              mm_a_q  <= acc_q;
              mm_b_q  <= b_q;
              state_q <= MUL_REQ;
            end else begin
              mm_a_q  <= b_q;
              mm_b_q  <= b_q;
              state_q <= SQR_REQ;
            end
          end
        end
        MUL_REQ: begin
          if (mm_done) begin
            acc_q      <= mm_result;
            mm_ready_q <= 1'b0;
            state_q    <= MUL_REL;
          end
        end
        MUL_REL: begin
          if (!mm_done) begin
            // The squaring after the top exponent bit would be wasted work.
            if ((e_q >> 1) == '0) begin
              result_q <= acc_q;
              state_q  <= DONE;
            end else begin
              mm_ready_q <= 1'b1;
              mm_a_q     <= b_q;
              mm_b_q     <= b_q;
              mm_n_q     <= n_q;
              state_q    <= SQR_REQ;
            end
          end
        end
        SQR_REQ: begin
          if (mm_done) begin
            b_q        <= mm_result;
            mm_ready_q <= 1'b0;
            state_q    <= SQR_REL;
          end
        end
        SQR_REL: begin
          if (!mm_done) begin
            e_q        <= e_q >> 1;
            mm_ready_q <= 1'b1;
            mm_n_q     <= n_q;
            if (e_q[1]) begin
              mm_a_q  <= acc_q;
              mm_b_q  <= b_q;
              state_q <= MUL_REQ;
            end else begin
              mm_a_q  <= b_q;
              mm_b_q  <= b_q;
              state_q <= SQR_REQ;
            end
          end
        end
        DONE: begin
          if (!done_q) begin
            done_q <= 1'b1;
          end else if (!modexp_start) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign modexp_done  = done_q;
  assign modexp_error = error_q;
  assign result       = result_q;
  assign mm_ready     = mm_ready_q;
  assign mm_a         = mm_a_q;
  assign mm_b         = mm_b_q;
  assign mm_n         = mm_n_q;
  assign dbg_state_o  = state_q;

endmodule
